// File: rtl/mlp_pkg.sv
// rtl/mlp_pkg.sv - shared types and constants for the MLP classifier slice
package mlp_pkg;

    localparam int PIX        = 16;
    localparam int SETTLE_DEF = 3;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_APPLY  = 3'd2,
        S_JUDGE  = 3'd3,
        S_UPDATE = 3'd4,
        S_EPEND  = 3'd5
    } sched_state_t;

endpackage

// File: rtl/mlp_train_sched_if.sv
// rtl/mlp_train_sched_if.sv - sample store and MLP side bus of the training scheduler
interface mlp_train_sched_if
    import mlp_pkg::*;
#(
    parameter int AW = 4
);
    logic [AW-1:0]  smp_addr;
    logic [PIX-1:0] smp_x;
    logic           smp_is_O;
    logic [PIX-1:0] x;
    logic           is_O;
    logic           learn;
    logic           y;

    modport master (
        output smp_addr, x, is_O, learn,
        input  smp_x, smp_is_O, y
    );

    modport slave (
        input  smp_addr, x, is_O, learn,
        output smp_x, smp_is_O, y
    );
endinterface

// File: rtl/mlp_sched_cnt.sv
// rtl/mlp_sched_cnt.sv - loadable down-counter with zero flag
module mlp_sched_cnt #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic [W-1:0] cnt,
    output logic         zero
);
    always_ff @(posedge clk) begin
        if (rst)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (dec && cnt != '0)
            cnt <= cnt - 1'b1;
    end

    assign zero = (cnt == '0);
endmodule

// File: rtl/mlp_train_sched.sv
// rtl/mlp_train_sched.sv - epoch/sample sequencer driving the O/X MLP training loop
module mlp_train_sched
    import mlp_pkg::*;
#(
    parameter int NSMP   = 16,
    parameter int AW     = 4,
    parameter int SETTLE = SETTLE_DEF,
    parameter int MAX_EP = 64,
    parameter int EW     = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    input  logic          mode,
    mlp_train_sched_if.master bus,
    output logic          busy,
    output logic          done,
    output logic          converged,
    output logic [EW-1:0] epoch_cnt,
    output logic [AW:0]   err_cnt
);
    localparam int CW = $clog2(SETTLE + 1);
    localparam logic [CW-1:0] HOLD_LOAD = CW'(SETTLE - 1);
    localparam logic [AW:0]   ERR_MAX   = '1;
    localparam logic [EW-1:0] EP_MAX    = '1;

    sched_state_t state, state_nx;
    logic          mode_q;
    logic          miss_q;
    logic [CW-1:0] hold_cnt;
    logic          hold_zero;
    logic          cnt_load, cnt_dec, x_load;
    logic          last_smp, run_end;

    assign last_smp = (bus.smp_addr == AW'(NSMP - 1));
    assign run_end  = (err_cnt == '0) || mode_q ||
                      (({1'b0, epoch_cnt} + (EW+1)'(1)) == (EW+1)'(MAX_EP));

    mlp_sched_cnt #(.W(CW)) u_hold (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (HOLD_LOAD),
        .dec      (cnt_dec),
        .cnt      (hold_cnt),
        .zero     (hold_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (abort && state != S_IDLE) begin
            state_nx = S_IDLE;
        end else begin
            case (state)
                S_IDLE:   if (start && !abort) state_nx = S_FETCH;
                S_FETCH:  state_nx = S_APPLY;
                S_APPLY:  if (hold_zero) state_nx = S_JUDGE;
                S_JUDGE:  state_nx = S_UPDATE;
                S_UPDATE: state_nx = last_smp ? S_EPEND : S_FETCH;
                S_EPEND:  state_nx = run_end ? S_IDLE : S_FETCH;
                default:  state_nx = S_IDLE;
            endcase
        end
    end

    // The hold counter still reads its load value only on the first APPLY cycle,
    // which is when the synchronous sample read has become valid.
    always_comb begin
        cnt_load  = (state == S_FETCH);
        cnt_dec   = (state == S_APPLY);
        x_load    = (state == S_APPLY) && (hold_cnt == HOLD_LOAD);
        bus.learn = (state == S_UPDATE) && miss_q && !mode_q && !abort && !rst;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q       <= 1'b0;
            miss_q       <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            converged    <= 1'b0;
            epoch_cnt    <= '0;
            err_cnt      <= '0;
            bus.smp_addr <= '0;
            bus.x        <= '0;
            bus.is_O     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (abort && state != S_IDLE) begin
                busy      <= 1'b0;
                done      <= 1'b1;
                converged <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: if (start && !abort) begin
                        mode_q       <= mode;
                        epoch_cnt    <= '0;
                        err_cnt      <= '0;
                        converged    <= 1'b0;
                        bus.smp_addr <= '0;
                        busy         <= 1'b1;
                    end
                    S_APPLY: if (x_load) begin
                        bus.x    <= bus.smp_x;
                        bus.is_O <= bus.smp_is_O;
                    end
                    S_JUDGE: begin
                        miss_q <= (bus.y != bus.is_O);
                        if (bus.y != bus.is_O && err_cnt != ERR_MAX)
                            err_cnt <= err_cnt + 1'b1;
                    end
                    S_UPDATE: if (!last_smp) bus.smp_addr <= bus.smp_addr + 1'b1;
                    S_EPEND: begin
                        if (epoch_cnt != EP_MAX) epoch_cnt <= epoch_cnt + 1'b1;
                        if (run_end) begin
                            converged <= (err_cnt == '0);
                            done      <= 1'b1;
                            busy      <= 1'b0;
                        end else begin
                            err_cnt      <= '0;
                            bus.smp_addr <= '0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_mlp_train_sched.sv
// tb/tb_mlp_train_sched.sv - directed self-checking bench for mlp_train_sched
module tb_mlp_train_sched;
    import mlp_pkg::*;

    localparam int NSMP = 16;
    localparam int AW   = 4;
    localparam int EW   = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          mode = 1'b0;
    logic          busy, done, converged;
    logic [EW-1:0] epoch_cnt;
    logic [AW:0]   err_cnt;

    mlp_train_sched_if #(.AW(AW)) bus ();

    mlp_train_sched #(.NSMP(NSMP), .AW(AW), .SETTLE(3), .MAX_EP(4), .EW(EW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .mode      (mode),
        .bus       (bus.master),
        .busy      (busy),
        .done      (done),
        .converged (converged),
        .epoch_cnt (epoch_cnt),
        .err_cnt   (err_cnt)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int failed = 0;
    int cyc = 0;
    int s_cyc = 0;
    int learn_cnt = 0;
    int learn_bad = 0;
    int done_seen = 0;
    int done_at = 0;
    int stub = 0;
    logic [15:0] last_learn_x = '0;
    logic [15:0] rom_x [NSMP];
    logic        rom_o [NSMP];
    logic        wrong;

    initial begin
        for (int i = 0; i < NSMP; i++) begin
            rom_x[i] = 16'(i * 16'h1357 + 16'h00A5);
            rom_o[i] = i[0];
        end
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        bus.smp_x    <= rom_x[bus.smp_addr];
        bus.smp_is_O <= rom_o[bus.smp_addr];
    end

    // y stub: 0 always right, 1 wrong on 3 and 9, 2 wrong on 5 for two epochs, 3 always wrong
    always_comb begin
        case (stub)
            1:       wrong = (bus.smp_addr == 4'd3) || (bus.smp_addr == 4'd9);
            2:       wrong = (bus.smp_addr == 4'd5) && (epoch_cnt < 8'd2);
            3:       wrong = 1'b1;
            default: wrong = 1'b0;
        endcase
        bus.y = bus.is_O ^ wrong;
    end

    always @(negedge clk) begin
        if (bus.learn) begin
            learn_cnt++;
            last_learn_x = bus.x;
            if (bus.x !== rom_x[bus.smp_addr]) learn_bad++;
        end
        if (done) begin
            done_seen++;
            done_at = cyc;
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic start_run(input logic m);
        @(negedge clk);
        start = 1'b1;
        mode = m;
        s_cyc = cyc;
        learn_cnt = 0;
        learn_bad = 0;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input int exp_lat);
        int n = 0;
        while (!done && n < budget) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (!done) begin
            failed++;
            $display("FAIL done_timeout: no done within %0d cycles", budget);
        end else if (cyc - s_cyc != exp_lat) begin
            failed++;
            $display("FAIL done_latency: got %0d expected %0d", cyc - s_cyc, exp_lat);
        end
        tests++;
        if (busy !== 1'b0) begin
            failed++;
            $display("FAIL busy_at_done: got %b expected 0", busy);
        end
    endtask

    task automatic wait_rel(input int n);
        while (cyc < s_cyc + n) @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        tests++;
        if ({busy, done, converged, bus.learn} !== 4'b0000) begin
            failed++;
            $display("FAIL reset_flags: got %b expected 0000", {busy, done, converged, bus.learn});
        end
        tests++;
        if (epoch_cnt !== 8'd0 || err_cnt !== 5'd0 || bus.smp_addr !== 4'd0) begin
            failed++;
            $display("FAIL reset_counts: ep=%0d err=%0d addr=%0d expected 0 0 0", epoch_cnt, err_cnt, bus.smp_addr);
        end
        tests++;
        if (bus.x !== 16'h0000 || bus.is_O !== 1'b0) begin
            failed++;
            $display("FAIL reset_x: x=%h is_O=%b expected 0000 0", bus.x, bus.is_O);
        end
    endtask

    task automatic test_eval_match();
        stub = 0;
        start_run(1'b1);
        wait_done(200, 98);
        tests++;
        if (converged !== 1'b1 || epoch_cnt !== 8'd1 || err_cnt !== 5'd0) begin
            failed++;
            $display("FAIL eval_match: conv=%b ep=%0d err=%0d expected 1 1 0", converged, epoch_cnt, err_cnt);
        end
        tests++;
        if (learn_cnt != 0) begin
            failed++;
            $display("FAIL eval_match_learn: got %0d pulses expected 0", learn_cnt);
        end
    endtask

    task automatic test_eval_errs();
        stub = 1;
        start_run(1'b1);
        wait_done(200, 98);
        tests++;
        if (converged !== 1'b0 || epoch_cnt !== 8'd1 || err_cnt !== 5'd2) begin
            failed++;
            $display("FAIL eval_errs: conv=%b ep=%0d err=%0d expected 0 1 2", converged, epoch_cnt, err_cnt);
        end
        tests++;
        if (learn_cnt != 0) begin
            failed++;
            $display("FAIL eval_errs_learn: got %0d pulses expected 0", learn_cnt);
        end
    endtask

    task automatic test_train_converge();
        stub = 2;
        start_run(1'b0);
        wait_done(500, 3 * 97 + 1);
        tests++;
        if (learn_cnt != 2 || learn_bad != 0) begin
            failed++;
            $display("FAIL train_learn: pulses=%0d bad_x=%0d expected 2 0", learn_cnt, learn_bad);
        end
        tests++;
        if (last_learn_x !== rom_x[5]) begin
            failed++;
            $display("FAIL train_learn_x: got %h expected %h", last_learn_x, rom_x[5]);
        end
        tests++;
        if (converged !== 1'b1 || epoch_cnt !== 8'd3 || err_cnt !== 5'd0) begin
            failed++;
            $display("FAIL train_conv: conv=%b ep=%0d err=%0d expected 1 3 0", converged, epoch_cnt, err_cnt);
        end
    endtask

    task automatic test_max_epochs();
        stub = 3;
        start_run(1'b0);
        wait_done(600, 4 * 97 + 1);
        tests++;
        if (learn_cnt != 64 || learn_bad != 0) begin
            failed++;
            $display("FAIL maxep_learn: pulses=%0d bad_x=%0d expected 64 0", learn_cnt, learn_bad);
        end
        tests++;
        if (converged !== 1'b0 || epoch_cnt !== 8'd4 || err_cnt !== 5'd16) begin
            failed++;
            $display("FAIL maxep_end: conv=%b ep=%0d err=%0d expected 0 4 16", converged, epoch_cnt, err_cnt);
        end
    endtask

    task automatic test_abort_restart();
        int d0;
        stub = 3;
        start_run(1'b0);
        wait_rel(100);
        tests++;
        if (epoch_cnt !== 8'd1 || busy !== 1'b1) begin
            failed++;
            $display("FAIL abort_pre: ep=%0d busy=%b expected 1 1", epoch_cnt, busy);
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        tests++;
        if (done !== 1'b1 || busy !== 1'b0 || converged !== 1'b0 || bus.learn !== 1'b0) begin
            failed++;
            $display("FAIL abort_end: done=%b busy=%b conv=%b learn=%b expected 1 0 0 0", done, busy, converged, bus.learn);
        end
        start = 1'b1;
        mode = 1'b0;
        s_cyc = cyc;
        learn_cnt = 0;
        learn_bad = 0;
        @(negedge clk);
        start = 1'b0;
        tests++;
        if (busy !== 1'b1 || epoch_cnt !== 8'd0 || bus.smp_addr !== 4'd0) begin
            failed++;
            $display("FAIL restart: busy=%b ep=%0d addr=%0d expected 1 0 0", busy, epoch_cnt, bus.smp_addr);
        end
        wait_rel(20);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(600, 4 * 97 + 1);
        tests++;
        if (epoch_cnt !== 8'd4 || learn_cnt != 64) begin
            failed++;
            $display("FAIL busy_start: ep=%0d pulses=%0d expected 4 64", epoch_cnt, learn_cnt);
        end
        @(negedge clk);
        d0 = done_seen;
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        @(negedge clk);
        tests++;
        if (busy !== 1'b0 || done_seen != d0) begin
            failed++;
            $display("FAIL abort_start_idle: busy=%b new_done=%0d expected 0 0", busy, done_seen - d0);
        end
    endtask

    task automatic test_reset_mid_run();
        int l0, d0;
        stub = 3;
        start_run(1'b0);
        wait_rel(40);
        rst = 1'b1;
        @(negedge clk);
        tests++;
        if ({busy, bus.learn, done} !== 3'b000 || bus.smp_addr !== 4'd0) begin
            failed++;
            $display("FAIL reset_mid: busy=%b learn=%b done=%b addr=%0d expected 0 0 0 0", busy, bus.learn, done, bus.smp_addr);
        end
        @(negedge clk);
        rst = 1'b0;
        l0 = learn_cnt;
        d0 = done_seen;
        repeat (30) @(negedge clk);
        tests++;
        if (learn_cnt != l0 || done_seen != d0 || busy !== 1'b0) begin
            failed++;
            $display("FAIL reset_mid_quiet: new_learn=%0d new_done=%0d busy=%b expected 0 0 0", learn_cnt - l0, done_seen - d0, busy);
        end
    endtask

    initial begin
        test_reset();
        test_eval_match();
        test_eval_errs();
        test_train_converge();
        test_max_epochs();
        test_abort_restart();
        test_reset_mid_run();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
